// File: rtl/sqrt_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_job_ctrl
// Summary  : Tagged-request sequencer in front of a Newton-Raphson sqrt core.
// Revision : 1.0  initial release
// ============================================================================
module sqrt_job_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [WIDTH-1:0]         i_in_x,
    input  logic [TAG_W-1:0]         i_in_tag,
    output logic                     o_sq_start,
    output logic [WIDTH-1:0]         o_sq_x,
    input  logic [WIDTH-1:0]         i_sq_y,
    input  logic                     i_sq_done,
    input  logic                     i_sq_error,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [WIDTH-1:0]         o_out_y,
    output logic [TAG_W-1:0]         o_out_tag,
    output logic                     o_out_error,
    output logic                     o_out_timeout,
    output logic                     o_fault,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_fifo_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_TW = $clog2(TIMEOUT);
    localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT - 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_mem_x   [DEPTH];
    logic [TAG_W-1:0]   r_mem_tag [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CW-1:0]    r_count;
    logic [c_TW-1:0]    r_timer;
    logic [WIDTH-1:0]   r_sq_x;
    logic [WIDTH-1:0]   r_out_y;
    logic [TAG_W-1:0]   r_out_tag;
    logic               r_out_error;
    logic               r_out_timeout;
    logic               r_fault;
    logic               r_live;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_head_small;
    logic [WIDTH-1:0]   w_head_x;
    logic [TAG_W-1:0]   w_head_tag;

    // r_live keeps in_ready low while reset is asserted and for the first cycle after.
    assign w_empty      = (r_count == '0);
    assign o_in_ready   = r_live & (r_count != c_FULL) & ~r_fault;
    assign w_push       = i_in_valid & o_in_ready;
    assign w_head_x     = r_mem_x[r_rd_ptr];
    assign w_head_tag   = r_mem_tag[r_rd_ptr];
    // The core's first guess is x>>1, which is zero for these operands.
    assign w_head_small = (w_head_x == '0) | (w_head_x == WIDTH'(1));

    assign o_sq_start    = (r_state == S_ISSUE);
    assign o_sq_x        = r_sq_x;
    assign o_out_valid   = (r_state == S_RESP);
    assign o_out_y       = r_out_y;
    assign o_out_tag     = r_out_tag;
    assign o_out_error   = r_out_error;
    assign o_out_timeout = r_out_timeout;
    assign o_fault       = r_fault;
    assign o_busy        = (r_state != S_IDLE) | ~w_empty;
    assign o_fifo_count  = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_x[r_wr_ptr]   <= i_in_x;
            r_mem_tag[r_wr_ptr] <= i_in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_live   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !r_fault) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_head_small ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_sq_done || (r_timer == c_TMAX)) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (i_out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer       <= '0;
            r_sq_x        <= '0;
            r_out_y       <= '0;
            r_out_tag     <= '0;
            r_out_error   <= 1'b0;
            r_out_timeout <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            if (w_pop) begin
                r_sq_x    <= w_head_x;
                r_out_tag <= w_head_tag;
                if (w_head_small) begin
                    r_out_y     <= w_head_x;
                    r_out_error <= 1'b0;
                end
            end
            case (r_state)
                S_ISSUE: r_timer <= '0;
                S_WAIT: begin
                    if (i_sq_done) begin
                        r_out_y     <= i_sq_error ? '0 : i_sq_y;
                        r_out_error <= i_sq_error;
                    end else if (r_timer == c_TMAX) begin
                        r_out_y       <= '0;
                        r_out_error   <= 1'b0;
                        r_out_timeout <= 1'b1;
                        r_fault       <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RESP: begin
                    if (i_out_ready) begin
                        r_out_error   <= 1'b0;
                        r_out_timeout <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sqrt_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqrt_job_ctrl
// Summary  : Self-checking bench with a behavioural sqrt core and result model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sqrt_job_ctrl;
    localparam int W = 32;
    localparam int TW = 4;
    localparam int D = 4;
    localparam int TO = 16;
    localparam int ITER = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [W-1:0] in_x = '0, sq_x, out_y;
    logic [TW-1:0] in_tag = '0, out_tag;
    logic sq_start, sq_done, sq_error, out_error, out_timeout, fault, busy;
    logic [W-1:0] sq_y;
    logic [2:0] fifo_count;
    logic hang = 1'b0;
    int total = 0;
    int bad = 0;
    int stab_viol = 0;

    always #5 clk = ~clk;

    sqrt_job_ctrl #(.WIDTH(W), .TAG_W(TW), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_x(in_x), .i_in_tag(in_tag),
        .o_sq_start(sq_start), .o_sq_x(sq_x), .i_sq_y(sq_y), .i_sq_done(sq_done),
        .i_sq_error(sq_error), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_y(out_y), .o_out_tag(out_tag), .o_out_error(out_error),
        .o_out_timeout(out_timeout), .o_fault(fault), .o_busy(busy),
        .o_fifo_count(fifo_count)
    );

    function automatic logic [W-1:0] isqrt(input logic [W-1:0] v);
        logic [W-1:0] r = '0;
        logic [63:0] t;
        for (int b = 15; b >= 0; b--) begin
            t = {32'd0, r | (32'd1 << b)};
            if (t * t <= {32'd0, v}) r = r | (32'd1 << b);
        end
        return r;
    endfunction

    // Expected {error, root} for a request, straight from the functional definition.
    function automatic logic [W:0] ref_result(input logic [W-1:0] x);
        if ($signed(x) < 0) return {1'b1, {W{1'b0}}};
        return {1'b0, isqrt(x)};
    endfunction

    // Behavioural core: negative x answers next cycle; otherwise done after ITER+1 cycles.
    logic [W-1:0] core_x;
    int core_cnt;
    logic core_active;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_done <= 1'b0; sq_error <= 1'b0; sq_y <= '0;
            core_cnt <= 0; core_active <= 1'b0; core_x <= '0;
        end else begin
            sq_done <= 1'b0;
            sq_error <= 1'b0;
            if (core_active && sq_x !== core_x) stab_viol <= stab_viol + 1;
            if (sq_start) begin
                core_x <= sq_x;
                if ($signed(sq_x) < 0) begin
                    sq_done <= 1'b1; sq_error <= 1'b1; sq_y <= '0; core_active <= 1'b0;
                end else begin
                    core_active <= !hang;
                    core_cnt <= ITER;
                end
            end else if (core_active) begin
                if (core_cnt == 1) begin
                    sq_done <= 1'b1; sq_y <= isqrt(core_x); core_active <= 1'b0;
                end
                core_cnt <= core_cnt - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W*2+TW+10:0] v;
        rst_n = 1'b0;
        tick(); tick();
        v = {in_ready, sq_start, sq_x, out_valid, out_y, out_tag, out_error,
             out_timeout, fault, busy, fifo_count};
        total++;
        if (v !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", v); end
        rst_n = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_release: in_ready=%b busy=%b want 1/0", in_ready, busy);
        end
    endtask

    task automatic test_single(input string name, input logic [W-1:0] x,
                               input logic [TW-1:0] tag, input int exp_lat);
        logic [W:0] e;
        int lat, starts, exp_starts;
        e = ref_result(x);
        exp_starts = (x == 0 || x == 1) ? 0 : 1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_x = x; in_tag = tag;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready); end
        tick();
        in_valid = 1'b0;
        lat = 0; starts = 0;
        while (!out_valid && lat < 60) begin
            if (sq_start) starts++;
            tick();
            lat++;
        end
        total++;
        if (lat !== exp_lat) begin bad++; $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat); end
        total++;
        if (out_y !== e[W-1:0] || out_tag !== tag || out_error !== e[W] || out_timeout !== 1'b0) begin
            bad++;
            $display("FAIL %s_result: got y=%0d tag=%0d err=%b to=%b want y=%0d tag=%0d err=%b to=0",
                     name, out_y, out_tag, out_error, out_timeout, e[W-1:0], tag, e[W]);
        end
        total++;
        if (starts !== exp_starts) begin bad++; $display("FAIL %s_starts: got %0d want %0d", name, starts, exp_starts); end
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_release: out_valid got %b want 0", name, out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] xs [4];
        int peak, got, cyc;
        logic [W:0] e;
        xs[0] = 32'd100; xs[1] = 32'd50; xs[2] = -32'sd4; xs[3] = 32'd1;
        out_ready = 1'b1;
        peak = 0; got = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_x = xs[i]; in_tag = TW'(i);
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        in_valid = 1'b0;
        cyc = 0;
        while (got < 4 && cyc < 200) begin
            @(negedge clk);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (out_valid) begin
                e = ref_result(xs[got]);
                total++;
                if (out_y !== e[W-1:0] || out_tag !== TW'(got) || out_error !== e[W]) begin
                    bad++;
                    $display("FAIL b2b_result[%0d]: got y=%0d tag=%0d err=%b want y=%0d tag=%0d err=%b",
                             got, out_y, out_tag, out_error, e[W-1:0], got, e[W]);
                end
                got++;
            end
            tick();
            cyc++;
        end
        total++;
        if (got !== 4) begin bad++; $display("FAIL b2b_count: got %0d results want 4", got); end
        total++;
        if (peak !== 3) begin bad++; $display("FAIL b2b_peak: fifo_count peak %0d want 3", peak); end
    endtask

    task automatic test_backpressure();
        logic [W+TW:0] q[$];
        logic [W+TW:0] exp;
        logic [W-1:0] xv;
        int cyc, starts;
        out_ready = 1'b0;
        in_valid = 1'b1; in_x = 32'd100; in_tag = 4'd5;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin tick(); cyc++; end
        total++;
        if (!out_valid) begin bad++; $display("FAIL bp_wait: out_valid got 0 want 1"); end
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 5) begin
                xv = (i == 4) ? 32'd999 : 32'(($urandom % 5000) + 2);
                in_valid = 1'b1; in_x = xv; in_tag = TW'(6 + i);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_y !== 32'd10 || out_tag !== 4'd5) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b y=%0d tag=%0d want v=1 y=10 tag=5", i, out_valid, out_y, out_tag);
            end
            if (sq_start) starts++;
            if (i < 4) begin
                total++;
                if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_push[%0d]: in_ready got %b want 1", i, in_ready); end
                q.push_back({ref_result(xv), TW'(6 + i)});
            end else if (i == 4) begin
                total++;
                if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin
                    bad++; $display("FAIL bp_full: in_ready=%b count=%0d want 0/4", in_ready, fifo_count);
                end
            end
            tick();
        end
        total++;
        if (starts !== 0) begin bad++; $display("FAIL bp_no_start: got %0d starts want 0", starts); end
        q.push_front({1'b0, 32'd10, 4'd5});
        out_ready = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 300) begin
            @(negedge clk);
            if (out_valid) begin
                exp = q.pop_front();
                total++;
                if ({out_error, out_y, out_tag} !== exp) begin
                    bad++;
                    $display("FAIL bp_drain: got err=%b y=%0d tag=%0d want err=%b y=%0d tag=%0d",
                             out_error, out_y, out_tag, exp[W+TW], exp[W+TW-1:TW], exp[TW-1:0]);
                end
            end
            tick();
            cyc++;
        end
        total++;
        if (q.size() !== 0) begin bad++; $display("FAIL bp_drain_count: %0d left want 0", q.size()); end
    endtask

    task automatic test_random();
        logic [W+TW:0] q[$];
        logic [W+TW:0] exp;
        logic [W-1:0] xv;
        int cyc;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            case ($urandom_range(0, 3))
                0: xv = 32'($urandom_range(0, 1));
                1: xv = -32'($urandom_range(1, 1000));
                2: xv = 32'($urandom_range(2, 1000));
                default: xv = $urandom & 32'h7fff_ffff;
            endcase
            in_valid = ($urandom_range(0, 1) == 1);
            in_x = xv;
            in_tag = TW'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (in_valid && in_ready) q.push_back({ref_result(in_x), in_tag});
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rand_extra: unexpected result y=%0d tag=%0d", out_y, out_tag);
                end else begin
                    exp = q.pop_front();
                    if ({out_error, out_y, out_tag} !== exp || out_timeout !== 1'b0) begin
                        bad++;
                        $display("FAIL rand_result: got err=%b y=%0d tag=%0d to=%b want err=%b y=%0d tag=%0d to=0",
                                 out_error, out_y, out_tag, out_timeout, exp[W+TW], exp[W+TW-1:TW], exp[TW-1:0]);
                    end
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while ((q.size() > 0 || busy) && cyc < 2000) begin
            @(negedge clk);
            if (out_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rand_extra: unexpected result y=%0d", out_y);
                end else begin
                    exp = q.pop_front();
                    if ({out_error, out_y, out_tag} !== exp) begin
                        bad++;
                        $display("FAIL rand_drain: got err=%b y=%0d tag=%0d want err=%b y=%0d tag=%0d",
                                 out_error, out_y, out_tag, exp[W+TW], exp[W+TW-1:TW], exp[TW-1:0]);
                    end
                end
            end
            tick();
            cyc++;
        end
        total++;
        if (q.size() !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL rand_final: %0d left busy=%b want 0/0", q.size(), busy);
        end
    endtask

    task automatic test_timeout();
        int lat, starts, valids;
        hang = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_x = 32'd50; in_tag = 4'd1;
        tick();
        in_x = 32'd9; in_tag = 4'd2;
        tick();
        in_valid = 1'b0;
        total++;
        if (sq_start !== 1'b1) begin bad++; $display("FAIL to_start: sq_start got %b want 1", sq_start); end
        lat = 0;
        while (!out_valid && lat < 60) begin tick(); lat++; end
        total++;
        if (lat !== TO + 1) begin bad++; $display("FAIL to_latency: got %0d want %0d", lat, TO + 1); end
        total++;
        if (out_timeout !== 1'b1 || out_y !== '0 || out_error !== 1'b0 || out_tag !== 4'd1 || fault !== 1'b1) begin
            bad++;
            $display("FAIL to_result: got to=%b y=%0d err=%b tag=%0d fault=%b want 1/0/0/1/1",
                     out_timeout, out_y, out_error, out_tag, fault);
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || fault !== 1'b1 || in_ready !== 1'b0 || fifo_count !== 3'd1) begin
            bad++;
            $display("FAIL to_after: v=%b fault=%b in_ready=%b count=%0d want 0/1/0/1",
                     out_valid, fault, in_ready, fifo_count);
        end
        starts = 0; valids = 0;
        for (int i = 0; i < 30; i++) begin
            if (sq_start) starts++;
            if (out_valid) valids++;
            tick();
        end
        total++;
        if (starts !== 0 || valids !== 0 || fifo_count !== 3'd1) begin
            bad++; $display("FAIL to_frozen: starts=%0d valids=%0d count=%0d want 0/0/1", starts, valids, fifo_count);
        end
        hang = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [W*2+TW+10:0] v;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_x = 32'(100 * (i + 1)); in_tag = TW'(i);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        total++;
        if (fifo_count !== 3'd2 || out_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL rst_mid_pre: count=%0d v=%b busy=%b want 2/0/1", fifo_count, out_valid, busy);
        end
        rst_n = 1'b0;
        #1;
        v = {in_ready, sq_start, sq_x, out_valid, out_y, out_tag, out_error,
             out_timeout, fault, busy, fifo_count};
        total++;
        if (v !== '0) begin bad++; $display("FAIL rst_mid_outputs: got %h want 0", v); end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (fifo_count !== 3'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid_post: count=%0d busy=%b in_ready=%b want 0/0/1", fifo_count, busy, in_ready);
        end
        test_single("post_reset", 32'd16, 4'd7, 13);
    endtask

    task automatic test_core_if();
        total++;
        if (stab_viol !== 0) begin bad++; $display("FAIL sq_x_stable: %0d changes while core busy want 0", stab_viol); end
    endtask

    initial begin
        test_reset();
        test_single("x16", 32'd16, 4'd3, 2 + ITER + 1);
        test_single("x0", 32'd0, 4'd8, 1);
        test_single("x1", 32'd1, 4'd9, 1);
        test_single("neg", -32'sd9, 4'd10, 3);
        test_back_to_back();
        test_backpressure();
        test_random();
        test_timeout();
        test_reset_mid();
        test_core_if();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
